// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus transmit sequencer feeding uart_tx.
// The producer pushes bytes with a one-cycle wr_en strobe. A small FSM
// drains them in order through the uart_tx send/busy handshake.
// Optional build macro UART_TX_FIFO_LEVEL_EN adds a 'level' output that
// mirrors the registered occupancy count.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_send,
  input  logic                  tx_busy
`ifdef UART_TX_FIFO_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0]   level
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEND       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  push;
  logic                  pop;

  // A write is admitted only against the registered full flag, so a pop in
  // the same cycle never makes room for a write while full is high.
  assign push = wr_en && !full;
  assign pop  = (state == IDLE) && !empty && !tx_busy;

  // Occupancy after this edge; a simultaneous push and pop cancel out.
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  // Storage array; contents survive reset and are never cleared.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Write pointer, occupancy, registered full/empty flags and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == {1'b1, {DEPTH_LOG2{1'b0}}});
    end
  end

  // Transmit sequencer: load a byte in IDLE, pulse send for one cycle, then
  // follow uart_tx busy through its rise and fall before loading again.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rd_ptr  <= '0;
      tx_data <= '0;
      tx_send <= 1'b0;
    end else begin
      tx_send <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1'b1;
            tx_send <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          state <= WAIT_START;
        end
        WAIT_START: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_LEVEL_EN
  assign level = count;
`endif

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte FIFO plus transmit sequencer between the command decoder's response output and uart_tx.
- Decoder pushes response bytes with a single-cycle write strobe at any rate up to the FIFO depth.
- Block drains bytes in order to uart_tx using its send/busy handshake, one byte per UART frame.
- Decoder never needs to observe busy.

Parameters:
DATA_WIDTH, 8, byte width of stored entries and tx_data.
DEPTH_LOG2, 4, log2 of FIFO depth (default depth 16 entries).

Ports:
clk  input  1  system clock (48 MHz HFOSC domain).
reset  input  1  synchronous, active-high reset.
wr_data  input  DATA_WIDTH  byte to enqueue.
wr_en  input  1  enqueue strobe, sampled each rising clk edge.
full  output  1  high when count == 2^DEPTH_LOG2.
empty  output  1  high when count == 0.
overflow  output  1  sticky: a write was attempted while full.
tx_data  output  DATA_WIDTH  byte presented to uart_tx data_in.
tx_send  output  1  one-cycle send pulse to uart_tx.
tx_busy  input  1  uart_tx busy flag.

Behaviour:
Reset (clk edge with reset=1), applied regardless of FSM state:
- rd_ptr = 0, wr_ptr = 0, count = 0.
- empty = 1, full = 0, overflow = 0.
- tx_data = 0, tx_send = 0, FSM = IDLE.
- Memory contents are not cleared.
- Reset mid-frame abandons the sequence; uart_tx completes its frame independently, and the block restarts in IDLE.

Storage:
- 2^DEPTH_LOG2 entries.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth.
- count is DEPTH_LOG2+1 bits.
- full and empty are registered, derived from next count.

Write rules:
- wr_en=1 and full=0: mem[wr_ptr] <= wr_data, wr_ptr++.
- wr_en=1 and full=1: byte dropped, pointers unchanged, overflow <= 1 (held until reset).
- full is evaluated on the registered value. A pop in the same cycle does not admit a write while full=1.

Read / FSM states:
- IDLE: if empty=0 and tx_busy=0, then tx_data <= mem[rd_ptr], rd_ptr++, go to SEND. Otherwise stay in IDLE.
- SEND: tx_send=1 for exactly this cycle; go to WAIT_START.
- WAIT_START: stay until tx_busy=1, then go to WAIT_DONE. uart_tx is required to raise busy within 1 cycle of send.
- WAIT_DONE: stay until tx_busy=0, then go to IDLE.
- tx_send is 0 in all states except SEND.
- tx_data holds its value from load until the next load.

Count and timing:
- A simultaneous accepted write and IDLE pop leave count unchanged. Pointers advance independently.
- Latency: write sampled at edge N into an empty FIFO with FSM IDLE and tx_busy=0 gives empty=0 after N, load at N+1, and tx_send high between edges N+1 and N+2.
- Minimum spacing between tx_send pulses: uart_tx frame time + 3 cycles (one WAIT_DONE-to-IDLE cycle, one IDLE load cycle, one SEND cycle).
- Bytes are emitted in strict write order, and every accepted byte is emitted exactly once.

Optional Feature:
UART_TX_FIFO_LEVEL_EN
- Defined: adds output port level, width DEPTH_LOG2+1, equal to the registered count (0..2^DEPTH_LOG2). Reset value 0.
- Undefined: level port and its logic are absent; all other behaviour is identical.

Test Plan:
- Single byte: reset, wr_data=8'h41 with wr_en for 1 cycle, tx_busy model rises 1 cycle after send and lasts 5000 cycles -> tx_send pulses once, 2 cycles after write, with tx_data=8'h41; empty returns to 1 at the load.
- Burst fill: 16 consecutive writes 8'h00..8'h0F while tx_busy is held 1 -> full=1 after 16th; 17th write 8'hFF dropped and overflow=1; releasing tx_busy drains 8'h00..8'h0F in order, with 8'hFF never sent.
- Simultaneous push/pop: with 3 entries queued, write 8'hAA in the same cycle as an IDLE load -> count stays 3 and 8'hAA is emitted last.
- Stretched busy: tx_busy held high 10 cycles before send, then normal frames -> no tx_send while busy; exactly one pulse per byte; no pulse during WAIT_START/WAIT_DONE.
- Reset mid-operation: assert reset during WAIT_DONE with 4 entries queued -> empty=1, tx_send=0, overflow=0; after release, one new write is sent normally and the old entries never appear.
- Wrap-around: push/pop 40 bytes 8'h10..8'h37 with at most 5 in flight -> all 40 emitted in order across pointer wrap; with UART_TX_FIFO_LEVEL_EN, level tracks count at every cycle.
